scroll_sequencer: RTL and testbench



---
 rtl/scroll_if.sv | 12 +
 rtl/scroll_sequencer.sv | 58 +++++
 tb/tb_scroll_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/scroll_if.sv
// scroll_if: control inputs and display outputs of the scroll sequencer.
interface scroll_if;
   logic       en;
   logic       dir;
   logic       step;
   logic [3:0] X;
   logic [3:0] AN;
   logic [3:0] base;
   logic       wrap;
   modport master (output en, dir, step, input X, AN, base, wrap);
   modport slave  (input en, dir, step, output X, AN, base, wrap);
endinterface

// File: rtl/scroll_sequencer.sv
// scroll_sequencer: 4-digit multiplexed message-scroll driver with run/pause, direction and single-step.
// Define BLANK_GUARD_EN to blank all digits for one clock whenever the digit select advances.
module scroll_sequencer #(
   parameter int DIG_DIV  = 50000,
   parameter int STEP_DIV = 250
) (
   input logic     clk,
   input logic     rst,
   scroll_if.slave bus
);
   localparam int CW = $clog2(DIG_DIV);
   localparam int SW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [SW-1:0] stp_q, stp_d;
   logic [1:0]    sel_q, sel_d;
   logic [3:0]    base_q, base_d, x_q, x_d, an_q, an_d;
   logic          wrap_q, wrap_d, tick, stp_last, move;
   always_comb begin
      tick     = cnt_q == CW'(DIG_DIV - 1);
      cnt_d    = tick ? '0 : cnt_q + 1'b1;
      sel_d    = sel_q + {1'b0, tick};
      stp_last = stp_q == SW'(STEP_DIV - 1);
      stp_d    = (bus.en && tick) ? (stp_last ? '0 : stp_q + 1'b1) : stp_q;
      // paused: every high step cycle is its own step, no edge detection
      move     = bus.en ? (tick && stp_last) : bus.step;
      base_d   = move ? (bus.dir ? base_q - 4'd1 : base_q + 4'd1) : base_q;
      wrap_d   = move && (bus.dir ? base_q == 4'd0 : base_q == 4'd15);
      x_d      = base_q + {2'b00, sel_q};
`ifdef BLANK_GUARD_EN
      an_d     = tick ? 4'b1111 : ~(4'b0001 << sel_q);
`else
      an_d     = ~(4'b0001 << sel_q);
`endif
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         stp_q  <= '0;
         sel_q  <= '0;
         base_q <= '0;
         x_q    <= '0;
         an_q   <= 4'b1111;
         wrap_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         stp_q  <= stp_d;
         sel_q  <= sel_d;
         base_q <= base_d;
         x_q    <= x_d;
         an_q   <= an_d;
         wrap_q <= wrap_d;
      end
   end
   assign bus.X    = x_q;
   assign bus.AN   = an_q;
   assign bus.base = base_q;
   assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_scroll_sequencer.sv
// tb_scroll_sequencer: randomized bench against an arithmetic model of the scroll sequencer.
module tb_scroll_sequencer;
   localparam int DIG_DIV  = 4;
   localparam int STEP_DIV = 2;
`ifdef BLANK_GUARD_EN
   localparam bit BLANK = 1'b1;
`else
   localparam bit BLANK = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;
   scroll_if ifc ();
   scroll_sequencer #(.DIG_DIV(DIG_DIV), .STEP_DIV(STEP_DIV)) dut (
      .clk(clk),
      .rst(rst),
      .bus(ifc.slave)
   );
   always #5 clk = ~clk;
   // model: k = clocks since reset release, rt = ticks seen while running
   int         k = 0, rt = 0, mb = 0, sl;
   logic [3:0] mx = '0, man = 4'hf;
   logic       mw = 1'b0, tk, mv;
   always @(posedge clk) begin
      if (rst) begin
         k = 0; rt = 0; mb = 0; mx = '0; man = 4'hf; mw = 1'b0;
      end else begin
         tk  = (k % DIG_DIV) == DIG_DIV - 1;
         sl  = (k / DIG_DIV) % 4;
         mx  = 4'((mb + sl) % 16);
         man = (BLANK && tk) ? 4'hf : ~(4'(1) << sl);
         mv  = 1'b0;
         if (ifc.en) begin
            if (tk) begin
               rt++;
               mv = (rt % STEP_DIV) == 0;
            end
         end else mv = ifc.step;
         mw = mv && (ifc.dir ? mb == 0 : mb == 15);
         if (mv) mb = (mb + (ifc.dir ? 15 : 1)) % 16;
         k++;
      end
   end
   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   task automatic cmp_all();
      chk("X", ifc.X, mx);
      chk("AN", ifc.AN, man);
      chk("base", ifc.base, mb);
      chk("wrap", ifc.wrap, mw);
   endtask
   task automatic cyc(input logic r, input logic e, input logic d, input logic s);
      rst = r; ifc.en = e; ifc.dir = d; ifc.step = s;
      @(posedge clk);
      @(negedge clk);
      cmp_all();
   endtask
   logic [3:0] an_t [5] = '{4'he, 4'hd, 4'hb, 4'h7, 4'he};
   logic [3:0] x_t  [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
   int         saved, wraps;
   logic       e, d;
   initial begin
      // reset state and refresh rotation while paused
      cyc(1, 0, 0, 0);
      chk("rst_AN", ifc.AN, 4'hf);
      chk("rst_X", ifc.X, 0);
      chk("rst_base", ifc.base, 0);
      chk("rst_wrap", ifc.wrap, 0);
      for (int j = 1; j <= 17; j++) begin
         cyc(0, 0, 0, 0);
         if (j % 4 == 1) begin
            chk("rot_AN", ifc.AN, an_t[j / 4]);
            chk("rot_X", ifc.X, x_t[j / 4]);
            chk("pin_rot_AN", man, an_t[j / 4]);
         end
      end
      // auto scroll: first step after two ticks
      cyc(1, 1, 0, 0);
      for (int j = 0; j < 7; j++) cyc(0, 1, 0, 0);
      chk("run_base7", ifc.base, 0);
      cyc(0, 1, 0, 0);
      chk("run_base8", ifc.base, 1);
      chk("pin_run_base8", mb, 1);
      // forward wrap 15 -> 0 while running
      cyc(1, 1, 0, 0);
      for (int j = 0; j < 8 * 15; j++) cyc(0, 1, 0, 0);
      chk("fwd_base15", ifc.base, 15);
      wraps = 0;
      for (int j = 0; j < 8; j++) begin
         cyc(0, 1, 0, 0);
         wraps += int'(ifc.wrap);
      end
      chk("fwd_wrap", ifc.wrap, 1);
      chk("fwd_base0", ifc.base, 0);
      cyc(0, 1, 0, 0);
      chk("fwd_wrap_off", ifc.wrap, 0);
      chk("fwd_wrap_count", wraps, 1);
      // reverse single steps while paused
      cyc(1, 0, 1, 0);
      cyc(0, 0, 1, 1);
      chk("rev_base15", ifc.base, 15);
      chk("rev_wrap", ifc.wrap, 1);
      chk("pin_rev_wrap", mw, 1);
      cyc(0, 0, 1, 0);
      chk("rev_wrap_off", ifc.wrap, 0);
      for (int j = 0; j < 3; j++) cyc(0, 0, 1, 1);
      chk("rev_hold3", ifc.base, 12);
      // step ignored while running, pause freezes base
      cyc(1, 1, 0, 0);
      for (int j = 0; j < 3; j++) cyc(0, 1, 0, 1);
      chk("run_step_ignored", ifc.base, 0);
      for (int j = 0; j < 10; j++) cyc(0, 1, 0, 1);
      saved = mb;
      for (int j = 0; j < 20; j++) cyc(0, 0, 0, 0);
      chk("pause_base", ifc.base, saved);
      // randomized mix of run, pause, step, direction and mid-run reset
      e = 1'b1; d = 1'b0;
      for (int j = 0; j < 3000; j++) begin
         if ($urandom_range(0, 39) == 0) e = ~e;
         if ($urandom_range(0, 15) == 0) d = ~d;
         cyc($urandom_range(0, 199) == 0, e, d, $urandom_range(0, 3) == 0);
      end
      cyc(0, 1, 0, 0);
      cyc(1, 1, 0, 0);
      chk("midrst_base", ifc.base, 0);
      chk("midrst_AN", ifc.AN, 4'hf);
      chk("midrst_X", ifc.X, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
